// File: rtl/spi_rx_master.sv
// SPI read-only master: clocks DATA_BITS bits in MSB-first
// and presents each completed word with a one-cycle strobe.
module spi_rx_master #(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_ena,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 spi_not_busy,
  output logic [DATA_BITS-1:0] spi_rx_data,
  output logic                 rx_valid
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SHIFT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                 state;
  logic [7:0]             div;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   div_done;

  assign div_done = (div == DIV_LAST);

  // Transaction sequencer; every output is a register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      spi_not_busy <= 1'b1;
      spi_rx_data  <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs_n         <= 1'b1;
          sclk         <= 1'b0;
          spi_not_busy <= 1'b1;
          div          <= '0;
          bit_cnt      <= '0;
          if (spi_ena) begin
            state        <= ASSERT;
            cs_n         <= 1'b0;
            spi_not_busy <= 1'b0;
            shreg        <= '0;
          end
        end
        ASSERT: begin
          if (div_done) begin
            div     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div <= div + 8'd1;
          end
        end
        SHIFT: begin
          if (div_done) begin
            div <= '0;
            if (!sclk) begin
              sclk  <= 1'b1;
              shreg <= {shreg[DATA_BITS-2:0], miso};
            end else begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state       <= RELEASE;
                cs_n        <= 1'b1;
                bit_cnt     <= '0;
                spi_rx_data <= shreg;
                rx_valid    <= 1'b1;
              end
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        RELEASE: begin
          if (div_done) begin
            div          <= '0;
            state        <= IDLE;
            spi_not_busy <= 1'b1;
          end else begin
            div <= div + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          cs_n         <= 1'b1;
          sclk         <= 1'b0;
          spi_not_busy <= 1'b1;
          div          <= '0;
          bit_cnt      <= '0;
        end
      endcase
    end
  end

endmodule
